// File: rtl/vga_timing_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_timing_if
// Brief    : Video raster bundle from the timing generator to the blanking stage.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_if;
  logic       hsync;
  logic       vsync;
  logic       h_display;
  logic       v_display;
  logic [9:0] x;
  logic [9:0] y;
  logic [1:0] R_out;
  logic [1:0] G_out;
  logic [1:0] B_out;
  logic       frame_start;

  modport master (
    output hsync, vsync, h_display, v_display, x, y,
    output R_out, G_out, B_out, frame_start
  );

  modport slave (
    input hsync, vsync, h_display, v_display, x, y,
    input R_out, G_out, B_out, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : VGA raster counters, sync/display decode and test-pattern colour.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   pattern_sel,
  vga_timing_if.master vid
);

  localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int c_BAR_W   = H_VISIBLE / 8;

  localparam logic [9:0] c_H_LAST     = 10'(c_H_TOTAL - 1);
  localparam logic [9:0] c_V_LAST     = 10'(c_V_TOTAL - 1);
  localparam logic [9:0] c_H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] c_V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] c_HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] c_HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] c_VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] c_VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic [1:0] r_mode;

  logic       r_hsync;
  logic       r_vsync;
  logic       r_h_display;
  logic       r_v_display;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic [1:0] r_red;
  logic [1:0] r_green;
  logic [1:0] r_blue;
  logic       r_frame_start;

  logic       w_origin;
  logic [1:0] w_mode;
  logic       w_h_vis;
  logic       w_v_vis;
  logic       w_hs_active;
  logic       w_vs_active;
  logic [2:0] w_bar;
  logic [1:0] w_red;
  logic [1:0] w_green;
  logic [1:0] w_blue;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == c_H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == c_V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  // The first pixel of a frame already uses the newly selected pattern.
  assign w_origin    = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
  assign w_mode      = w_origin ? pattern_sel : r_mode;
  assign w_h_vis     = (r_h_cnt < c_H_VIS);
  assign w_v_vis     = (r_v_cnt < c_V_VIS);
  assign w_hs_active = (r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END);
  assign w_vs_active = (r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END);

  // Bar index h / (H_VISIBLE/8); the grey ramp is its upper two bits.
  always_comb begin
    w_bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (r_h_cnt >= 10'(i * c_BAR_W)) begin
        w_bar = 3'(i);
      end
    end
  end

  always_comb begin
    w_red   = 2'd0;
    w_green = 2'd0;
    w_blue  = 2'd0;
    if (w_h_vis && w_v_vis) begin
      case (w_mode)
        2'd0: begin
          w_red   = 2'd3;
          w_green = 2'd3;
          w_blue  = 2'd3;
        end
        2'd1: begin
          w_red   = {2{w_bar[2]}};
          w_green = {2{w_bar[1]}};
          w_blue  = {2{w_bar[0]}};
        end
        2'd2: begin
          w_red   = w_bar[2:1];
          w_green = w_bar[2:1];
          w_blue  = w_bar[2:1];
        end
        default: begin
          w_red   = {2{r_h_cnt[5] ^ r_v_cnt[5]}};
          w_green = {2{r_h_cnt[5] ^ r_v_cnt[5]}};
          w_blue  = {2{r_h_cnt[5] ^ r_v_cnt[5]}};
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode        <= 2'd0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_h_display   <= 1'b0;
      r_v_display   <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_red         <= '0;
      r_green       <= '0;
      r_blue        <= '0;
      r_frame_start <= 1'b0;
    end else begin
      if (w_origin) begin
        r_mode <= pattern_sel;
      end
      r_hsync       <= w_hs_active ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_vs_active ? SYNC_POL : ~SYNC_POL;
      r_h_display   <= w_h_vis;
      r_v_display   <= w_v_vis;
      r_x           <= r_h_cnt;
      r_y           <= r_v_cnt;
      r_red         <= w_red;
      r_green       <= w_green;
      r_blue        <= w_blue;
      r_frame_start <= w_origin;
    end
  end

  assign vid.hsync       = r_hsync;
  assign vid.vsync       = r_vsync;
  assign vid.h_display   = r_h_display;
  assign vid.v_display   = r_v_display;
  assign vid.x           = r_x;
  assign vid.y           = r_y;
  assign vid.R_out       = r_red;
  assign vid.G_out       = r_green;
  assign vid.B_out       = r_blue;
  assign vid.frame_start = r_frame_start;

endmodule
`default_nettype wire
